button_event_arbiter: RTL and testbench

// - Sits downstream of the per-button debounce instances; consumes N debounced levels (btn_db).
// - Runs one press/hold state machine per button and generates PRESS, RELEASE and LONG events.
// - A round-robin arbiter serialises all events onto one valid/ready stream for the control FSM.
// - Replaces ad-hoc edge detection in consumers.

---
 rtl/button_event_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//
// Turns N debounced button levels into PRESS / RELEASE / LONG (and optionally
// REPEAT) events and serialises them onto one valid/ready stream using a
// round-robin arbiter over one pending slot per button.
//
// Ports
//   clk           system clock, single domain
//   rst_n         asynchronous assert, active-low reset
//   btn_db        debounced button levels, already synchronous to clk
//   evt_valid     event available on evt_id/evt_kind
//   evt_ready     consumer ready
//   evt_id        index of the button that produced the event
//   evt_kind      0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   overflow      sticky flag: an event was dropped because its slot was full
//   clr_overflow  synchronous clear of overflow (a same-cycle drop wins)
//
// Handshake: an event transfers on a rising clk edge where evt_valid and
// evt_ready are both 1. While evt_valid is 1 and evt_ready is 0, evt_id and
// evt_kind hold their values. evt_valid never drops without a transfer.
//
// Optional feature: define BTN_AUTOREPEAT_EN to emit REPEAT events every
// REPEAT_CYCLES while a button stays held after LONG. Without it, the
// long-held state only waits for release and kind 3 never appears.
// -----------------------------------------------------------------------------
module button_event_arbiter #(
  parameter int N_BTN         = 4,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_db,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_kind,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int ID_W = $clog2(N_BTN);

  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_RELEASE = 2'd1;
  localparam logic [1:0] KIND_LONG    = 2'd2;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [1:0]       KIND_REPEAT = 2'd3;
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Elaboration-time guard against parameter values the counters cannot honour.
  if (N_BTN < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("button_event_arbiter: N_BTN, LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_LONGH = 2'd2
  } state_t;

  state_t           r_state     [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [CNT_W-1:0] r_cnt       [N_BTN];
  logic [CNT_W-1:0] w_cnt_nxt   [N_BTN];
  logic [N_BTN-1:0] w_raise;
  logic [1:0]       w_raise_k   [N_BTN];

  logic [N_BTN-1:0] r_pend_v;
  logic [N_BTN-1:0] w_pend_v_nxt;
  logic [1:0]       r_pend_k     [N_BTN];
  logic [1:0]       w_pend_k_nxt [N_BTN];

  logic [ID_W-1:0]  r_rr;
  logic [ID_W-1:0]  w_gnt_id;
  logic [ID_W-1:0]  w_rr_nxt;
  logic [ID_W:0]    w_sum;
  logic             w_free;
  logic             w_gnt_v;
  logic             w_drop;

  // ---------------------------------------------------------------------------
  // Per-button press/hold FSMs: next state, counter and raised event.
  // Release is checked first so it wins over LONG/REPEAT in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_raise[i]     = 1'b0;
      w_raise_k[i]   = KIND_PRESS;
      case (r_state[i])
        S_IDLE: begin
          if (btn_db[i]) begin
            w_raise[i]     = 1'b1;
            w_raise_k[i]   = KIND_PRESS;
            w_cnt_nxt[i]   = '0;
            w_state_nxt[i] = S_HELD;
          end
        end
        S_HELD: begin
          if (!btn_db[i]) begin
            w_raise[i]     = 1'b1;
            w_raise_k[i]   = KIND_RELEASE;
            w_state_nxt[i] = S_IDLE;
          end else if (r_cnt[i] == LONG_LAST) begin
            w_raise[i]     = 1'b1;
            w_raise_k[i]   = KIND_LONG;
            w_cnt_nxt[i]   = '0;
            w_state_nxt[i] = S_LONGH;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
          end
        end
        S_LONGH: begin
          if (!btn_db[i]) begin
            w_raise[i]     = 1'b1;
            w_raise_k[i]   = KIND_RELEASE;
            w_state_nxt[i] = S_IDLE;
`ifdef BTN_AUTOREPEAT_EN
          end else if (r_cnt[i] == REP_LAST) begin
            w_raise[i]     = 1'b1;
            w_raise_k[i]   = KIND_REPEAT;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
`else
          end else begin
            w_cnt_nxt[i]   = '0;
`endif
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin grant: scan slots starting at r_rr, wrapping at N_BTN.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_free   = !evt_valid || evt_ready;
    w_gnt_v  = 1'b0;
    w_gnt_id = '0;
    w_sum    = '0;
    if (w_free) begin
      for (int k = 0; k < N_BTN; k++) begin
        w_sum = {1'b0, r_rr} + (ID_W+1)'(k);
        if (w_sum >= (ID_W+1)'(N_BTN)) begin
          w_sum = w_sum - (ID_W+1)'(N_BTN);
        end
        if (!w_gnt_v && r_pend_v[w_sum[ID_W-1:0]]) begin
          w_gnt_v  = 1'b1;
          w_gnt_id = w_sum[ID_W-1:0];
        end
      end
    end
    w_rr_nxt = (w_gnt_id == ID_W'(N_BTN - 1)) ? '0 : w_gnt_id + ID_W'(1);
  end

  // Pending slots: a slot being granted this cycle counts as free, so a new
  // event can replace it without loss.
  always_comb begin
    w_drop = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      w_pend_v_nxt[i] = r_pend_v[i];
      w_pend_k_nxt[i] = r_pend_k[i];
      if (w_raise[i]) begin
        if (!r_pend_v[i] || (w_gnt_v && w_gnt_id == ID_W'(i))) begin
          w_pend_v_nxt[i] = 1'b1;
          w_pend_k_nxt[i] = w_raise_k[i];
        end else begin
          w_drop = 1'b1;
        end
      end else if (w_gnt_v && w_gnt_id == ID_W'(i)) begin
        w_pend_v_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_pend_k[i] <= KIND_PRESS;
      end
      r_rr      <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_kind  <= KIND_PRESS;
      overflow  <= 1'b0;
    end else begin
      r_pend_v <= w_pend_v_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        r_pend_k[i] <= w_pend_k_nxt[i];
      end
      if (w_free) begin
        if (w_gnt_v) begin
          evt_valid <= 1'b1;
          evt_id    <= w_gnt_id;
          evt_kind  <= r_pend_k[w_gnt_id];
          r_rr      <= w_rr_nxt;
        end else begin
          evt_valid <= 1'b0;
        end
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_event_arbiter
//
// Directed scenarios followed by randomized traffic. Expected outputs come
// from a behavioural model that derives events from press time and elapsed
// hold time, then routes them through per-button slots and a rotating
// priority search. Handshaked events are also checked in order against an
// expected queue filled when the model grants an event.
// -----------------------------------------------------------------------------
module tb_button_event_arbiter;

  localparam int N = 4;
  localparam int L = 8;
  localparam int R = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_db = '0;
  logic         evt_ready = 1'b0;
  logic         clr_overflow = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [1:0]   evt_kind;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  button_event_arbiter #(
    .N_BTN        (N),
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_db      (btn_db),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_kind    (evt_kind),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit   m_held    [N];
  int   m_press_t [N];
  bit   m_pv      [N];
  int   m_pk      [N];
  int   m_rr;
  bit   m_valid;
  int   m_id;
  int   m_kind;
  bit   m_ovf;
  int   m_t;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_held[i]    = 1'b0;
      m_press_t[i] = 0;
      m_pv[i]      = 1'b0;
      m_pk[i]      = 0;
    end
    m_rr    = 0;
    m_valid = 1'b0;
    m_id    = 0;
    m_kind  = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour, from the inputs seen at it.
  task automatic model_step(input logic [N-1:0] b, input logic rdy, input logic clr);
    bit rv [N];
    int rk [N];
    int d, g, gk, j;
    bit drop, free;
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0;
      rk[i] = 0;
      if (!m_held[i] && b[i]) begin
        rv[i] = 1'b1; rk[i] = 0;
        m_held[i] = 1'b1; m_press_t[i] = m_t;
      end else if (m_held[i] && !b[i]) begin
        rv[i] = 1'b1; rk[i] = 1;
        m_held[i] = 1'b0;
      end else if (m_held[i]) begin
        d = m_t - m_press_t[i];
        if (d == L) begin
          rv[i] = 1'b1; rk[i] = 2;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (d > L && ((d - L) % R) == 0) begin
          rv[i] = 1'b1; rk[i] = 3;
        end
`endif
      end
    end
    free = !m_valid || rdy;
    g  = -1;
    gk = 0;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && m_pv[j]) g = j;
      end
    end
    if (g >= 0) gk = m_pk[g];
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rv[i]) begin
        if (!m_pv[i] || g == i) begin
          m_pv[i] = 1'b1; m_pk[i] = rk[i];
        end else begin
          drop = 1'b1;
        end
      end else if (g == i) begin
        m_pv[i] = 1'b0;
      end
    end
    if (free) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_id = g; m_kind = gk;
        m_rr = (g + 1) % N;
        e = {g[1:0], gk[1:0]};
        exp_q.push_back(e);
      end else begin
        m_valid = 1'b0;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_t++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, advance one edge, compare against the model.
  // Called at 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic [N-1:0] b, input logic rdy, input logic clr);
    logic hs;
    logic [W-1:0] hs_evt, e;
    btn_db       = b;
    evt_ready    = rdy;
    clr_overflow = clr;
    hs     = evt_valid && rdy;
    hs_evt = {evt_id, evt_kind};
    @(posedge clk);
    model_step(b, rdy, clr);
    #1;
    if (hs) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected observed=%0d expected=none", hs_evt);
      end else begin
        e = exp_q.pop_front();
        chk("sb_evt", 32'(hs_evt), 32'(e));
      end
    end
    chk("valid", 32'(evt_valid), 32'(m_valid));
    chk("id",    32'(evt_id),    32'(m_id));
    chk("kind",  32'(evt_kind),  32'(m_kind));
    chk("ovf",   32'(overflow),  32'(m_ovf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] b;
    m_t = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", 32'(evt_valid), 32'(0));
    chk("rst_id",    32'(evt_id),    32'(0));
    chk("rst_kind",  32'(evt_kind),  32'(0));
    chk("rst_ovf",   32'(overflow),  32'(0));

    // 1. single tap on button 2
    cyc(4'b0100, 1'b1, 1'b0);
    chk("tap_lat0", 32'(evt_valid), 32'(0));
    cyc(4'b0100, 1'b1, 1'b0);
    chk("tap_valid", 32'(evt_valid), 32'(1));
    chk("tap_id",    32'(evt_id),    32'(2));
    chk("tap_kind",  32'(evt_kind),  32'(0));
    cyc(4'b0100, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b1, 1'b0);

    // 2. long hold on button 1
    for (int c = 0; c < 20; c++) cyc(4'b0010, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b1, 1'b0);

    // 3. simultaneous presses from rr = 0, then from a rotated rr
    do_reset();
    cyc(4'b1111, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      chk("sim_valid", 32'(evt_valid), 32'(1));
      chk("sim_id",    32'(evt_id),    32'(j));
      chk("sim_kind",  32'(evt_kind),  32'(0));
    end
    for (int c = 0; c < 8; c++) cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("rr_rot_id", 32'(evt_id), 32'(2));
    for (int c = 0; c < 4; c++) cyc(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) cyc(4'b0000, 1'b1, 1'b0);

    // 4. backpressure
    do_reset();
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cyc(4'b0001, 1'b0, 1'b0);
      chk("bp_valid", 32'(evt_valid), 32'(1));
      chk("bp_id",    32'(evt_id),    32'(0));
      chk("bp_kind",  32'(evt_kind),  32'(0));
    end
    cyc(4'b0000, 1'b1, 1'b0);
    chk("bp_next_valid", 32'(evt_valid), 32'(1));
    chk("bp_next_kind",  32'(evt_kind),  32'(2));
    for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b1, 1'b0);

    // 5. overflow
    do_reset();
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'(1));
    cyc(4'b0000, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'(1));
    cyc(4'b0000, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'(0));
    for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b1, 1'b0);

    // 6. reset in the middle of a hold
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'b1000, 1'b0, 1'b0);
    chk("mid_pre_valid", 32'(evt_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1000, 1'b1, 1'b0);
    chk("mid_lat0", 32'(evt_valid), 32'(0));
    cyc(4'b1000, 1'b1, 1'b0);
    chk("mid_press_valid", 32'(evt_valid), 32'(1));
    chk("mid_press_id",    32'(evt_id),    32'(3));
    chk("mid_press_kind",  32'(evt_kind),  32'(0));
    for (int c = 0; c < 12; c++) cyc(4'b1000, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b1, 1'b0);

    // randomized traffic: mostly-ready phase, then heavy backpressure
    do_reset();
    b = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
      end
      cyc(b, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      end
      cyc(b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
    end
    for (int c = 0; c < 12; c++) cyc(4'b0000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
